cpu_clock_switch_ctrl: RTL and testbench
========================================

# cpu_clock_switch_ctrl

Sequencer for the CPU clock selection on the accelerator. Runs on C7M; debounces the speed switch and clock jumpers, waits for an idle 68000 bus, then drives the two dynamic clock selectors and the final slow/turbo mux in a fixed, glitch-safe order. It replaces the free-running jumper decode: the clock tree only changes when this block commits a new setting.

## Interface
- DEBOUNCE_CYCLES, 16384: C7M cycles a requested setting must stay stable (~2.3 ms).
- IDLE_CYCLES, 4: consecutive synchronized AS_CPU_n-high cycles required before any output change.
- SETTLE_CYCLES, 64: C7M cycles waited after a DCS select change before the mux step.
- C7M  in  1  block clock (7.09 MHz).
- RESET_n  in  1  asynchronous active-low reset.
- CPU_SPEED_SWITCH  in  1  async; 1 = force C7M.
- JP2, JP3, JP4  in  1 each  async jumper inputs; code = {JP2,JP3,JP4}.
- AS_CPU_n  in  1  async CPU address strobe.
- CLKSEL0  out  4  one-hot select for DCS0 (C7M/C14M/C21M/C28M).
- CLKSEL1  out  4  one-hot select for DCS1 (C33M/C42M/C50M/OSC).
- BANK_SEL  out  1  0 = DCS0 output, 1 = DCS1 output.
- SLOW_SEL  out  1  1 = CPU clock is C7M.
- SWITCHING  out  1  high from SEL step through MUX step inclusive.

## Operation
- All async inputs pass through 2-flop synchronizers; request word R = {CPU_SPEED_SWITCH, JP2, JP3, JP4}, 4 bits.
- Applied word A: reset value 4'b1000 (slow, code 000). Reset outputs: CLKSEL0=0001, CLKSEL1=0001, BANK_SEL=0, SLOW_SEL=1, SWITCHING=0.
- Decode: bank = code[2]; one-hot index = code[1:0]; CLKSEL of the non-target bank is left unchanged.
- States: IDLE, DEBOUNCE, WAIT_BUS, SEL, SETTLE, MUX.
- IDLE: if R != A -> DEBOUNCE, latch candidate C = R, clear counter.
- DEBOUNCE: R != C -> reload C, restart counter. Counter reaches DEBOUNCE_CYCLES-1 -> WAIT_BUS. If C == A on completion -> IDLE.
- WAIT_BUS: idle counter counts while sync AS_CPU_n = 1, clears when 0; reaching IDLE_CYCLES -> SEL. R != C -> DEBOUNCE (nothing changed yet).
- SEL (1 cycle): if C[3]=0, write target bank's CLKSEL; if C[3]=1, no CLKSEL change; -> SETTLE.
- SETTLE: count SETTLE_CYCLES, then require IDLE_CYCLES idle again -> MUX. If C[3]=1 the settle count is skipped.
- MUX (1 cycle): SLOW_SEL <= C[3]; BANK_SEL <= C[2] if C[3]=0 else unchanged; A <= C; -> IDLE.
- Request changes during SEL/SETTLE/MUX are ignored until IDLE; the sequence always completes, then the new request is debounced.
- Switch to slow is only mux; from slow to turbo the DCS select is set first, mux last.
- Reset mid-sequence: all outputs return to reset values immediately (async); after release, a non-slow request is re-debounced from scratch.

## Timing
- All outputs registered; no combinational input-to-output path.
- Minimum latency from stable R to MUX output change: 2 (sync) + DEBOUNCE_CYCLES + IDLE_CYCLES + 1 + SETTLE_CYCLES + IDLE_CYCLES cycles (bus continuously idle).
- CLKSEL change and BANK_SEL/SLOW_SEL change are never in the same cycle.
- Exactly one bit set in each CLKSEL at all times.

## Configuration
- CLKSW_PLL_LOCK_EN defined: adds input PLL_LOCK [1:0] (bit0 = C7M PLL, bit1 = oscillator PLL), synchronized. SETTLE additionally waits until the PLL feeding the target clock is locked (codes 001,010,101 -> bit0; 100,110 -> bit1; 000,011,111 -> none). SETTLE count still applies.
- Undefined: no port; lock treated as always asserted.

## Structure
- Package clksw_pkg: state enum, REQ_W=4, CODE_W=3, one-hot decode function, reset constants for A and CLKSEL.
- Sub-module clksw_sync: 2-flop synchronizer with reset value parameter, instantiated per async input (AS_CPU_n resets to 1).

## Test plan
- Reset, R=0000, AS high -> SLOW_SEL falls to 0 after ~DEBOUNCE_CYCLES+IDLE_CYCLES+SETTLE_CYCLES+IDLE_CYCLES+4 cycles; CLKSEL0 stays 0001, BANK_SEL=0.
- R from 1000 to 0110 -> CLKSEL1 becomes 0100 in SEL, BANK_SEL=1 and SLOW_SEL=0 exactly SETTLE_CYCLES+IDLE_CYCLES+1 cycles later; CLKSEL0 unchanged.
- JP3 toggles every 1000 cycles for 10 toggles, then stable at 1 -> no output change until DEBOUNCE_CYCLES after last toggle.
- AS_CPU_n held low in WAIT_BUS for 500 cycles -> no output change; releases -> SEL after IDLE_CYCLES.
- From 0011, R changes to 0101 during SETTLE -> first sequence completes (A=0011), then second sequence yields CLKSEL1=0010, BANK_SEL=1.
- RESET_n pulsed low during SETTLE -> outputs return to reset values same cycle; with CLKSW_PLL_LOCK_EN, PLL_LOCK=00 holds SETTLE for 0110 until bit1 set.

Source files
------------

// File: rtl/clksw_pkg.sv
// rtl/clksw_pkg.sv - shared types, widths and reset constants for the CPU clock switch sequencer
package clksw_pkg;

    localparam int REQ_W  = 4;
    localparam int CODE_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_WAIT_BUS,
        ST_SEL,
        ST_SETTLE,
        ST_MUX
    } state_t;

    // Applied word after reset: slow mode, clock code 000.
    localparam logic [REQ_W-1:0] APPLIED_RESET = 4'b1000;
    localparam logic [3:0]       CLKSEL_RESET  = 4'b0001;

    function automatic logic [3:0] onehot_sel(input logic [1:0] idx);
        onehot_sel = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/clksw_sync.sv
// rtl/clksw_sync.sv - two-flop synchronizer with a configurable reset value
module clksw_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // next values of the two capture stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // capture stages, forced to the idle level of the input during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cpu_clock_switch_ctrl.sv
// rtl/cpu_clock_switch_ctrl.sv - debounced, bus-idle-gated CPU clock select sequencer (optional CLKSW_PLL_LOCK_EN)
module cpu_clock_switch_ctrl
    import clksw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16384,
    parameter int IDLE_CYCLES     = 4,
    parameter int SETTLE_CYCLES   = 64
) (
    input  logic       C7M,
    input  logic       RESET_n,
    input  logic       CPU_SPEED_SWITCH,
    input  logic       JP2,
    input  logic       JP3,
    input  logic       JP4,
    input  logic       AS_CPU_n,
`ifdef CLKSW_PLL_LOCK_EN
    input  logic [1:0] PLL_LOCK,
`endif
    output logic [3:0] CLKSEL0,
    output logic [3:0] CLKSEL1,
    output logic       BANK_SEL,
    output logic       SLOW_SEL,
    output logic       SWITCHING
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CNT = (MAX_A > IDLE_CYCLES) ? MAX_A : IDLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [REQ_W-1:0] req_s;
    logic             as_s;
    logic             lock_ok;

    state_t           state_q, state_d;
    logic [REQ_W-1:0] cand_q, cand_d;
    logic [REQ_W-1:0] applied_q, applied_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             settled_q, settled_d;
    logic [3:0]       clksel0_q, clksel0_d;
    logic [3:0]       clksel1_q, clksel1_d;
    logic             bank_q, bank_d;
    logic             slow_q, slow_d;
    logic             switching_q, switching_d;

    clksw_sync #(.RESET_VAL(1'b1)) u_sync_spd (.clk(C7M), .rst_n(RESET_n), .d(CPU_SPEED_SWITCH), .q(req_s[3]));
    clksw_sync #(.RESET_VAL(1'b0)) u_sync_jp2 (.clk(C7M), .rst_n(RESET_n), .d(JP2),              .q(req_s[2]));
    clksw_sync #(.RESET_VAL(1'b0)) u_sync_jp3 (.clk(C7M), .rst_n(RESET_n), .d(JP3),              .q(req_s[1]));
    clksw_sync #(.RESET_VAL(1'b0)) u_sync_jp4 (.clk(C7M), .rst_n(RESET_n), .d(JP4),              .q(req_s[0]));
    clksw_sync #(.RESET_VAL(1'b1)) u_sync_as  (.clk(C7M), .rst_n(RESET_n), .d(AS_CPU_n),         .q(as_s));

`ifdef CLKSW_PLL_LOCK_EN
    logic [1:0] pll_s;

    clksw_sync #(.RESET_VAL(1'b0)) u_sync_pll0 (.clk(C7M), .rst_n(RESET_n), .d(PLL_LOCK[0]), .q(pll_s[0]));
    clksw_sync #(.RESET_VAL(1'b0)) u_sync_pll1 (.clk(C7M), .rst_n(RESET_n), .d(PLL_LOCK[1]), .q(pll_s[1]));

    // lock status of the PLL that feeds the pending target clock; C7M itself needs none
    always_comb begin
        lock_ok = 1'b1;
        if (!cand_q[3]) begin
            case (cand_q[CODE_W-1:0])
                3'b001, 3'b010, 3'b101: lock_ok = pll_s[0];
                3'b100, 3'b110:         lock_ok = pll_s[1];
                default:                lock_ok = 1'b1;
            endcase
        end
    end
`else
    assign lock_ok = 1'b1;
`endif

    // sequencer next state: debounce, wait for idle bus, select, settle, mux
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        applied_d = applied_q;
        cnt_d     = cnt_q;
        settled_d = settled_q;
        clksel0_d = clksel0_q;
        clksel1_d = clksel1_q;
        bank_d    = bank_q;
        slow_d    = slow_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s != applied_q) begin
                    state_d = ST_DEBOUNCE;
                    cand_d  = req_s;
                    cnt_d   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (req_s != cand_q) begin
                    cand_d = req_s;
                    cnt_d  = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = (cand_q == applied_q) ? ST_IDLE : ST_WAIT_BUS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_BUS: begin
                // nothing has been driven yet, so a new request simply restarts debounce
                if (req_s != cand_q) begin
                    state_d = ST_DEBOUNCE;
                    cand_d  = req_s;
                    cnt_d   = '0;
                end else if (!as_s) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SEL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEL: begin
                // going slow never touches the DCS selects; only the target bank is rewritten
                if (!cand_q[3]) begin
                    if (cand_q[2]) begin
                        clksel1_d = onehot_sel(cand_q[1:0]);
                    end else begin
                        clksel0_d = onehot_sel(cand_q[1:0]);
                    end
                end
                cnt_d     = '0;
                settled_d = cand_q[3];
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!settled_q) begin
                    if (cnt_q == SETTLE_LAST) begin
                        settled_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!as_s || !lock_ok) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_MUX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MUX: begin
                slow_d = cand_q[3];
                if (!cand_q[3]) begin
                    bank_d = cand_q[2];
                end
                applied_d = cand_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        switching_d = (state_d == ST_SEL) || (state_d == ST_SETTLE) || (state_d == ST_MUX);
    end

    // state and registered outputs; reset drops straight back to slow C7M
    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= ST_IDLE;
            cand_q      <= APPLIED_RESET;
            applied_q   <= APPLIED_RESET;
            cnt_q       <= '0;
            settled_q   <= 1'b0;
            clksel0_q   <= CLKSEL_RESET;
            clksel1_q   <= CLKSEL_RESET;
            bank_q      <= 1'b0;
            slow_q      <= 1'b1;
            switching_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            applied_q   <= applied_d;
            cnt_q       <= cnt_d;
            settled_q   <= settled_d;
            clksel0_q   <= clksel0_d;
            clksel1_q   <= clksel1_d;
            bank_q      <= bank_d;
            slow_q      <= slow_d;
            switching_q <= switching_d;
        end
    end

    assign CLKSEL0   = clksel0_q;
    assign CLKSEL1   = clksel1_q;
    assign BANK_SEL  = bank_q;
    assign SLOW_SEL  = slow_q;
    assign SWITCHING = switching_q;

endmodule

// File: tb/tb_cpu_clock_switch_ctrl.sv
// tb/tb_cpu_clock_switch_ctrl.sv - self-checking bench for cpu_clock_switch_ctrl
module tb_cpu_clock_switch_ctrl;

    localparam int DEB      = 32;
    localparam int IDL      = 4;
    localparam int SET      = 16;
    localparam int SEQ_WAIT = DEB + 2 * IDL + SET + 20;

    logic       C7M              = 1'b0;
    logic       RESET_n          = 1'b0;
    logic       CPU_SPEED_SWITCH = 1'b1;
    logic       JP2              = 1'b0;
    logic       JP3              = 1'b0;
    logic       JP4              = 1'b0;
    logic       AS_CPU_n         = 1'b1;
`ifdef CLKSW_PLL_LOCK_EN
    logic [1:0] PLL_LOCK         = 2'b11;
`endif
    logic [3:0] CLKSEL0;
    logic [3:0] CLKSEL1;
    logic       BANK_SEL;
    logic       SLOW_SEL;
    logic       SWITCHING;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] c0;
        logic [3:0] c1;
        logic       bank;
        logic       slow;
    } vec_t;

    vec_t vecs[8];

    always #5 C7M = ~C7M;

    cpu_clock_switch_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .IDLE_CYCLES    (IDL),
        .SETTLE_CYCLES  (SET)
    ) dut (
        .C7M             (C7M),
        .RESET_n         (RESET_n),
        .CPU_SPEED_SWITCH(CPU_SPEED_SWITCH),
        .JP2             (JP2),
        .JP3             (JP3),
        .JP4             (JP4),
        .AS_CPU_n        (AS_CPU_n),
`ifdef CLKSW_PLL_LOCK_EN
        .PLL_LOCK        (PLL_LOCK),
`endif
        .CLKSEL0         (CLKSEL0),
        .CLKSEL1         (CLKSEL1),
        .BANK_SEL        (BANK_SEL),
        .SLOW_SEL        (SLOW_SEL),
        .SWITCHING       (SWITCHING)
    );

    // cycle-by-cycle watch: one-hot selects, never CLKSEL and mux in the same cycle
    logic       mon_on = 1'b0;
    int         mon_err = 0;
    logic [3:0] p_c0, p_c1;
    logic       p_b, p_s, p_rst;
    always @(negedge C7M) begin
        if (mon_on) begin
            if (RESET_n && p_rst &&
                ((CLKSEL0 != p_c0) || (CLKSEL1 != p_c1)) &&
                ((BANK_SEL != p_b) || (SLOW_SEL != p_s)))
                mon_err++;
            if (!$onehot(CLKSEL0) || !$onehot(CLKSEL1))
                mon_err++;
        end
        p_c0  = CLKSEL0;
        p_c1  = CLKSEL1;
        p_b   = BANK_SEL;
        p_s   = SLOW_SEL;
        p_rst = RESET_n;
    end

    task automatic tick();
        @(posedge C7M);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        {CPU_SPEED_SWITCH, JP2, JP3, JP4} = r;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] c0, input logic [3:0] c1,
                            input logic bank, input logic slow, input logic sw);
        chk({tag, "_clksel0"},   CLKSEL0,   c0);
        chk({tag, "_clksel1"},   CLKSEL1,   c1);
        chk({tag, "_bank_sel"},  BANK_SEL,  bank);
        chk({tag, "_slow_sel"},  SLOW_SEL,  slow);
        chk({tag, "_switching"}, SWITCHING, sw);
    endtask

    initial begin
        int   n;
        int   t_sel;
        int   t_mux;
        logic quiet;

        vecs[0] = '{4'b0011, 4'b1000, 4'b0100, 1'b0, 1'b0};
        vecs[1] = '{4'b1011, 4'b1000, 4'b0100, 1'b0, 1'b1};
        vecs[2] = '{4'b0101, 4'b1000, 4'b0010, 1'b1, 1'b0};
        vecs[3] = '{4'b1101, 4'b1000, 4'b0010, 1'b1, 1'b1};
        vecs[4] = '{4'b0111, 4'b1000, 4'b1000, 1'b1, 1'b0};
        vecs[5] = '{4'b0001, 4'b0010, 4'b1000, 1'b0, 1'b0};
        vecs[6] = '{4'b0001, 4'b0010, 4'b1000, 1'b0, 1'b0};
        vecs[7] = '{4'b1000, 4'b0010, 4'b1000, 1'b0, 1'b1};

        // reset state
        repeat (3) tick();
        chk_outs("reset", 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0);
        RESET_n = 1'b1;
        repeat (2) tick();
        mon_on = 1'b1;

        // first turbo request: end-to-end latency with the bus idle
        set_req(4'b0000);
        n = 0;
        while (SLOW_SEL && n < 500) begin
            tick();
            n++;
        end
        chk("latency_window", (n >= DEB + 2 * IDL + SET + 3) && (n <= DEB + 2 * IDL + SET + 6), 1);
        chk_outs("to_0000", 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        // bank 1 request: select change precedes the mux by SETTLE+IDLE+1 cycles
        set_req(4'b0110);
        n = 0;
        t_sel = -1;
        t_mux = -1;
        while (n < 500 && t_mux < 0) begin
            tick();
            n++;
            if (t_sel < 0 && CLKSEL1 != 4'b0001) t_sel = n;
            if (BANK_SEL) t_mux = n;
        end
        chk("sel_to_mux_cycles", t_mux - t_sel, SET + IDL + 1);
        chk_outs("to_0110", 4'b0001, 4'b0100, 1'b1, 1'b0, 1'b0);

        // table of committed settings
        for (int i = 0; i < 8; i++) begin
            set_req(vecs[i].req);
            repeat (SEQ_WAIT) tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].c0, vecs[i].c1, vecs[i].bank, vecs[i].slow, 1'b0);
        end

        // JP3 bouncing faster than the debounce window: nothing commits until it holds
        set_req(4'b0010);
        quiet = 1'b1;
        for (int k = 0; k < 10; k++) begin
            repeat (10) begin
                tick();
                if (SWITCHING || !SLOW_SEL) quiet = 1'b0;
            end
            JP3 = ~JP3;
        end
        chk("bounce_quiet", quiet, 1'b1);
        n = 0;
        while (SLOW_SEL && n < 500) begin
            tick();
            n++;
        end
        chk("bounce_settle_after_last", (n >= DEB) && (n < 500), 1);
        chk_outs("to_0010", 4'b0100, 4'b1000, 1'b0, 1'b0, 1'b0);

        // busy bus holds the sequence in WAIT_BUS
        AS_CPU_n = 1'b0;
        set_req(4'b0110);
        quiet = 1'b1;
        repeat (DEB + 200) begin
            tick();
            if (SWITCHING || BANK_SEL || CLKSEL1 != 4'b1000) quiet = 1'b0;
        end
        chk("bus_busy_quiet", quiet, 1'b1);
        AS_CPU_n = 1'b1;
        n = 0;
        while (!SWITCHING && n < 100) begin
            tick();
            n++;
        end
        chk("bus_release_to_sel", (n >= IDL) && (n <= IDL + 3), 1);
        repeat (SET + IDL + 10) tick();
        chk_outs("to_0110_bus", 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);

        // request changed during SETTLE: first completes, then the second runs
        set_req(4'b0011);
        n = 0;
        while (!SWITCHING && n < 500) begin
            tick();
            n++;
        end
        repeat (5) tick();
        set_req(4'b0101);
        n = 0;
        while (SWITCHING && n < 500) begin
            tick();
            n++;
        end
        chk_outs("first_of_two", 4'b1000, 4'b0100, 1'b0, 1'b0, 1'b0);
        repeat (SEQ_WAIT) tick();
        chk_outs("second_of_two", 4'b1000, 4'b0010, 1'b1, 1'b0, 1'b0);

        // reset during SETTLE: immediate return to slow, request re-debounced afterwards
        set_req(4'b0001);
        n = 0;
        while (!SWITCHING && n < 500) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("pre_reset_clksel0", CLKSEL0, 4'b0010);
        RESET_n = 1'b0;
        #1;
        chk_outs("mid_reset", 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0);
        tick();
        RESET_n = 1'b1;
        repeat (DEB / 2) tick();
        chk("post_reset_still_slow", {SWITCHING, SLOW_SEL}, 2'b01);
        repeat (SEQ_WAIT) tick();
        chk_outs("post_reset_commit", 4'b0010, 4'b0001, 1'b0, 1'b0, 1'b0);

`ifdef CLKSW_PLL_LOCK_EN
        // oscillator PLL unlocked holds SETTLE for code 110
        PLL_LOCK = 2'b01;
        set_req(4'b0110);
        repeat (SEQ_WAIT + 20) tick();
        chk("pll_hold_switching", SWITCHING, 1'b1);
        chk("pll_hold_bank", BANK_SEL, 1'b0);
        PLL_LOCK = 2'b11;
        repeat (IDL + 10) tick();
        chk_outs("pll_locked", 4'b0010, 4'b0100, 1'b1, 1'b0, 1'b0);
`endif

        chk("onehot_and_order", mon_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
